// File: rtl/pc_sequencer_if.sv
// Fetch-side bus of the PC sequencer: control requests in, fetch address and
// status out. The sequencer uses the slave modport; whatever drives the
// requests (pipeline control, or a bench) uses the master modport.
// The history read port exists only when PC_HISTORY_EN is defined.
interface pc_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic              stall_i;
    logic              fetch_ready_i;
    logic              branch_i;
    logic [ADDR_W-1:0] branch_target_i;
    logic              jump_i;
    logic [ADDR_W-1:0] jump_target_i;
    logic              exc_i;
    logic              halt_i;
    logic              resume_i;
    logic [ADDR_W-1:0] pc_o;
    logic [ADDR_W-1:0] pc_next_o;
    logic              fetch_valid_o;
    logic              redirect_o;
    logic              misalign_o;
    logic              halted_o;
    logic [CNT_W-1:0]  fetch_cnt_o;
`ifdef PC_HISTORY_EN
    logic [1:0]        hist_sel_i;
    logic [ADDR_W+1:0] hist_o;
`endif

`ifdef PC_HISTORY_EN
    modport slave (
        input  stall_i, fetch_ready_i, branch_i, branch_target_i, jump_i,
               jump_target_i, exc_i, halt_i, resume_i, hist_sel_i,
        output pc_o, pc_next_o, fetch_valid_o, redirect_o, misalign_o,
               halted_o, fetch_cnt_o, hist_o
    );
    modport master (
        output stall_i, fetch_ready_i, branch_i, branch_target_i, jump_i,
               jump_target_i, exc_i, halt_i, resume_i, hist_sel_i,
        input  pc_o, pc_next_o, fetch_valid_o, redirect_o, misalign_o,
               halted_o, fetch_cnt_o, hist_o
    );
`else
    modport slave (
        input  stall_i, fetch_ready_i, branch_i, branch_target_i, jump_i,
               jump_target_i, exc_i, halt_i, resume_i,
        output pc_o, pc_next_o, fetch_valid_o, redirect_o, misalign_o,
               halted_o, fetch_cnt_o
    );
    modport master (
        output stall_i, fetch_ready_i, branch_i, branch_target_i, jump_i,
               jump_target_i, exc_i, halt_i, resume_i,
        input  pc_o, pc_next_o, fetch_valid_o, redirect_o, misalign_o,
               halted_o, fetch_cnt_o
    );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter unit for the fetch stage. Generates the fetch address,
// advances it on accepted fetches, applies prioritised redirects
// (exception > branch > jump) and runs a BOOT/RUN/HALT state machine.
// Optional redirect history buffer: define PC_HISTORY_EN.
module pc_sequencer #(
    parameter int              ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = 32'h0000_0080,
    parameter int              INSTR_BYTES  = 4,
    parameter int              BOOT_CYCLES  = 2,
    parameter int              CNT_W        = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } state_t;

    // Low address bits that must be zero for an instruction-aligned target.
    localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'(INSTR_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_INC    = ADDR_W'(INSTR_BYTES);
    localparam logic [3:0]        BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        boot_cnt_q, boot_cnt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              redirect_q, redirect_d;
    logic              misalign_q, misalign_d;
    logic [CNT_W-1:0]  fetch_cnt_q;
    logic              accept;

    // Only a RUN-state fetch can be accepted; stall blocks acceptance.
    assign accept = (state_q == ST_RUN) & bus.fetch_ready_i & ~bus.stall_i;

    // Next-state, next-PC and redirect flags.
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        pc_d       = pc_q;
        redirect_d = 1'b0;
        misalign_d = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                // Requests are ignored while booting; PC stays at reset vector.
                boot_cnt_d = boot_cnt_q + 4'd1;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.exc_i) begin
                    pc_d       = EXC_VECTOR;
                    redirect_d = 1'b1;
                end else if (bus.branch_i) begin
                    pc_d       = bus.branch_target_i & ~LOW_MASK;
                    redirect_d = 1'b1;
                    misalign_d = |(bus.branch_target_i & LOW_MASK);
                end else if (bus.jump_i) begin
                    pc_d       = bus.jump_target_i & ~LOW_MASK;
                    redirect_d = 1'b1;
                    misalign_d = |(bus.jump_target_i & LOW_MASK);
                end else if (accept) begin
                    pc_d = pc_q + PC_INC;
                end
                // An exception in the same cycle cancels the halt request.
                if (bus.halt_i && !bus.exc_i) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                // Branch/jump are ignored here; exception forces a restart.
                if (bus.exc_i) begin
                    pc_d       = EXC_VECTOR;
                    redirect_d = 1'b1;
                    state_d    = ST_RUN;
                end else if (bus.resume_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State, PC and one-cycle status pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= 4'd0;
            pc_q       <= RESET_VECTOR;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            misalign_q <= misalign_d;
        end
    end

    // Accepted-fetch counter; counts accepts even when a redirect overrides them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_cnt_q <= '0;
        end else if (accept) begin
            fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
        end
    end

    assign bus.pc_o          = pc_q;
    assign bus.pc_next_o     = pc_d;
    assign bus.fetch_valid_o = (state_q == ST_RUN);
    assign bus.halted_o      = (state_q == ST_HALT);
    assign bus.redirect_o    = redirect_q;
    assign bus.misalign_o    = misalign_q;
    assign bus.fetch_cnt_o   = fetch_cnt_q;

`ifdef PC_HISTORY_EN
    logic [ADDR_W+1:0] hist_q [4];
    logic [1:0]        hist_wr_q;
    logic [1:0]        hist_src;

    // Source of a redirect: in HALT only an exception can redirect, so a
    // non-exception redirect is a branch if requested, otherwise a jump.
    assign hist_src = bus.exc_i ? 2'd0 : (bus.branch_i ? 2'd1 : 2'd2);

    // Circular history of applied redirects, newest at hist_wr_q-1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) begin
                hist_q[i] <= '0;
            end
            hist_wr_q <= 2'd0;
        end else if (redirect_d) begin
            hist_q[hist_wr_q] <= {hist_src, pc_d};
            hist_wr_q         <= hist_wr_q + 2'd1;
        end
    end

    assign bus.hist_o = hist_q[hist_wr_q - 2'd1 - bus.hist_sel_i];
`endif
endmodule
